alu: RTL and testbench

- Registered RV32I execute-stage ALU.
- Takes decoded instruction fields plus operand values from the decode/register-file stage.
- Produces a 32-bit result and a branch-taken flag, one clock after the inputs are sampled.
- Covers R-type, I-type ALU, branch, LUI, AUIPC, JAL/JALR link and load/store address generation.

---
 rtl/alu.sv | 100 ++++++++++
 tb/tb_alu.sv | 115 +++++++++++
 2 files changed

// File: rtl/alu.sv
// Registered RV32I execute-stage ALU.
// Decodes on opcode/funct3/funct7 and produces the result plus the branch decision one clock later.
module alu #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [6:0]      opcode,
  input  logic [4:0]      rd,
  input  logic [2:0]      funct3,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] imm,
  input  logic [2:0]      instr_type,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic [XLEN-1:0] alu_result,
  output logic            branch_taken
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;

  // Register addresses and decoder class are carried along but not needed here.
  logic unused_fields;
  assign unused_fields = ^{rd, rs1_addr, rs2_addr, instr_type, funct7[6], funct7[4:0]};

  logic [XLEN-1:0] op_b, alu_val, res_d;
  logic [4:0]      shamt;
  logic            alt, br_d;
  logic            eq, lt_s, lt_u;

  assign op_b  = (opcode == OP_R) ? rs2_data : imm;
  assign shamt = op_b[4:0];
  assign alt   = funct7[5];

  always_comb begin
    alu_val = '0;
    unique case (funct3)
      // Only R-type may subtract; ADDI's imm[10] must never turn it into SUB.
      3'b000: alu_val = (opcode == OP_R && alt) ? rs1_data - op_b : rs1_data + op_b;
      3'b001: alu_val = rs1_data << shamt;
      3'b010: alu_val = {{(XLEN-1){1'b0}}, $signed(rs1_data) < $signed(op_b)};
      3'b011: alu_val = {{(XLEN-1){1'b0}}, rs1_data < op_b};
      3'b100: alu_val = rs1_data ^ op_b;
      3'b101: alu_val = alt ? XLEN'($signed(rs1_data) >>> shamt) : rs1_data >> shamt;
      3'b110: alu_val = rs1_data | op_b;
      3'b111: alu_val = rs1_data & op_b;
      default: alu_val = '0;
    endcase
  end

  assign eq   = rs1_data == rs2_data;
  assign lt_s = $signed(rs1_data) < $signed(rs2_data);
  assign lt_u = rs1_data < rs2_data;

  always_comb begin
    res_d = '0;
    br_d  = 1'b0;
    case (opcode)
      OP_R, OP_I:         res_d = alu_val;
      OP_LUI:             res_d = imm;
      OP_AUIPC:           res_d = pc + imm;
      OP_JAL, OP_JALR:    res_d = pc + XLEN'(4);
      OP_LOAD, OP_STORE:  res_d = rs1_data + imm;
      OP_BRANCH: begin
        case (funct3)
          3'b000:  br_d = eq;
          3'b001:  br_d = ~eq;
          3'b100:  br_d = lt_s;
          3'b101:  br_d = ~lt_s;
          3'b110:  br_d = lt_u;
          3'b111:  br_d = ~lt_u;
          default: br_d = 1'b0;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_result   <= '0;
      branch_taken <= 1'b0;
    end else begin
      alu_result   <= res_d;
      branch_taken <= br_d;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for the registered ALU: one instruction per cycle, checked one edge later.
module tb_alu;
  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1_addr, rs2_addr;
  logic [2:0]  funct3, instr_type;
  logic [6:0]  funct7;
  logic [31:0] imm, pc, rs1_data, rs2_data;
  logic [31:0] alu_result;
  logic        branch_taken;

  int checks = 0;
  int errors = 0;

  localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, B = 7'b1100011;

  alu #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .rd(rd), .funct3(funct3),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .funct7(funct7), .imm(imm),
    .instr_type(instr_type), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .alu_result(alu_result), .branch_taken(branch_taken)
  );

  always #5 clk = ~clk;

  // Apply one instruction, clock it, and sample 1 time unit after the edge.
  task automatic step(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] im, input logic [31:0] p);
    opcode = op; funct3 = f3; funct7 = f7;
    rs1_data = a; rs2_data = b; imm = im; pc = p;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] r_exp, input logic b_exp);
    checks++;
    assert (alu_result === r_exp) else begin
      errors++;
      $error("FAIL %s result got=%h exp=%h", tag, alu_result, r_exp);
    end
    checks++;
    assert (branch_taken === b_exp) else begin
      errors++;
      $error("FAIL %s branch_taken got=%b exp=%b", tag, branch_taken, b_exp);
    end
  endtask

  initial begin
    rd = 5'd3; rs1_addr = 5'd1; rs2_addr = 5'd2; instr_type = 3'd0;
    rst = 1'b1;
    step(R, 3'b000, 7'h00, 32'd10, 32'd20, 32'd0, 32'd0);
    chk("reset_edge1", 32'd0, 1'b0);
    step(R, 3'b000, 7'h00, 32'd10, 32'd20, 32'd0, 32'd0);
    chk("reset_edge2", 32'd0, 1'b0);
    rst = 1'b0;
    step(R, 3'b000, 7'h00, 32'd10, 32'd20, 32'd0, 32'd0);
    chk("add_after_reset", 32'd30, 1'b0);

    // R-type
    step(R, 3'b000, 7'h20, 32'd10, 32'd20, 32'd0, 32'd0);              chk("sub", 32'hFFFFFFF6, 1'b0);
    step(R, 3'b010, 7'h00, 32'd5, 32'd10, 32'd0, 32'd0);               chk("slt", 32'd1, 1'b0);
    step(R, 3'b010, 7'h00, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0);         chk("slt_neg", 32'd1, 1'b0);
    step(R, 3'b011, 7'h00, 32'hFFFFFFFE, 32'd10, 32'd0, 32'd0);        chk("sltu", 32'd0, 1'b0);
    step(R, 3'b111, 7'h00, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'd0, 32'd0);  chk("and", 32'd0, 1'b0);
    step(R, 3'b110, 7'h00, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'd0, 32'd0);  chk("or", 32'hFFFFFFFF, 1'b0);
    step(R, 3'b100, 7'h00, 32'hAAAA5555, 32'h5555AAAA, 32'd0, 32'd0);  chk("xor", 32'hFFFFFFFF, 1'b0);
    step(R, 3'b100, 7'h20, 32'h0000FFFF, 32'h00FF00FF, 32'd0, 32'd0);  chk("xor_f7", 32'h00FFFF00, 1'b0);
    step(R, 3'b001, 7'h00, 32'd1, 32'd5, 32'd0, 32'd0);                chk("sll", 32'd32, 1'b0);
    step(R, 3'b001, 7'h00, 32'd1, 32'd37, 32'd0, 32'd0);               chk("sll_shamt5", 32'd32, 1'b0);
    step(R, 3'b101, 7'h20, 32'h80000000, 32'd4, 32'd0, 32'd0);         chk("sra", 32'hF8000000, 1'b0);
    step(R, 3'b101, 7'h00, 32'h80000000, 32'd4, 32'd0, 32'd0);         chk("srl", 32'h08000000, 1'b0);

    // I-type: operand B comes from imm, rs2_data is a decoy
    step(I, 3'b000, 7'h00, 32'd10, 32'd99, 32'd15, 32'd0);             chk("addi", 32'd25, 1'b0);
    step(I, 3'b101, 7'h20, 32'hFFFFFFF0, 32'd99, 32'h00000402, 32'd0); chk("srai", 32'hFFFFFFFC, 1'b0);
    step(I, 3'b101, 7'h00, 32'hFFFFFFF0, 32'd99, 32'h00000002, 32'd0); chk("srli", 32'h3FFFFFFC, 1'b0);
    step(I, 3'b000, 7'h20, 32'd10, 32'd99, 32'h00000400, 32'd0);       chk("addi_f7", 32'h0000040A, 1'b0);

    // Branches
    step(B, 3'b000, 7'h00, 32'd30, 32'd30, 32'd8, 32'h100);            chk("beq", 32'd0, 1'b1);
    step(B, 3'b001, 7'h00, 32'd30, 32'd30, 32'd8, 32'h100);            chk("bne", 32'd0, 1'b0);
    step(B, 3'b100, 7'h00, 32'd10, 32'd20, 32'd8, 32'h100);            chk("blt", 32'd0, 1'b1);
    step(B, 3'b100, 7'h00, 32'hFFFFFFFF, 32'd1, 32'd8, 32'h100);       chk("blt_neg", 32'd0, 1'b1);
    step(B, 3'b101, 7'h00, 32'hFFFFFFFF, 32'd1, 32'd8, 32'h100);       chk("bge_neg", 32'd0, 1'b0);
    step(B, 3'b110, 7'h00, 32'hFFFFFFFF, 32'd1, 32'd8, 32'h100);       chk("bltu", 32'd0, 1'b0);
    step(B, 3'b111, 7'h00, 32'hFFFFFFFF, 32'd1, 32'd8, 32'h100);       chk("bgeu", 32'd0, 1'b1);
    step(B, 3'b010, 7'h00, 32'd5, 32'd5, 32'd8, 32'h100);              chk("b_f3_010", 32'd0, 1'b0);

    // Upper immediate, jumps, address generation
    step(7'b0110111, 3'b000, 7'h00, 32'd7, 32'd9, 32'h1000, 32'h40);    chk("lui", 32'h1000, 1'b0);
    step(7'b0010111, 3'b000, 7'h00, 32'd7, 32'd9, 32'h1000, 32'h2000);  chk("auipc", 32'h3000, 1'b0);
    step(7'b1101111, 3'b000, 7'h00, 32'd7, 32'd9, 32'h80, 32'h100);     chk("jal", 32'h104, 1'b0);
    step(7'b1100111, 3'b000, 7'h00, 32'd7, 32'd9, 32'h80, 32'h200);     chk("jalr", 32'h204, 1'b0);
    step(7'b0000011, 3'b010, 7'h00, 32'h40, 32'd9, 32'hFFFFFFFC, 32'd0); chk("load", 32'h3C, 1'b0);
    step(7'b0100011, 3'b010, 7'h00, 32'h100, 32'd9, 32'd8, 32'd0);      chk("store", 32'h108, 1'b0);

    // Illegal opcode
    step(7'b1111111, 3'b000, 7'h20, 32'h1234, 32'h1234, 32'h55, 32'h10); chk("bad_opcode", 32'd0, 1'b0);

    // Back-to-back: taken branch then ADD must clear branch_taken
    step(B, 3'b000, 7'h00, 32'd4, 32'd4, 32'd0, 32'd0);                chk("b2b_beq", 32'd0, 1'b1);
    step(R, 3'b000, 7'h00, 32'd4, 32'd4, 32'd0, 32'd0);                chk("b2b_add", 32'd8, 1'b0);

    // Mid-stream reset discards the in-flight result, then first post-reset edge registers inputs
    rst = 1'b1;
    step(B, 3'b000, 7'h00, 32'd1, 32'd1, 32'd0, 32'd0);                chk("mid_reset", 32'd0, 1'b0);
    rst = 1'b0;
    step(R, 3'b110, 7'h00, 32'h00F0, 32'h000F, 32'd0, 32'd0);          chk("post_reset_or", 32'h00FF, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
